demod_cfg_sequencer: RTL and testbench
======================================

Name: demod_cfg_sequencer

Overview:
- Autonomous configuration loader for the legacy demodulator register bus (rd, wr0..wr3, 12-bit addr, 32-bit din/dout).
- On start, walks a synchronous table of {byte-lane mask, addr, data} entries and issues byte-lane writes into the demod register space.
- Shares the bus with the host processor. Host has absolute priority; sequencer writes stall around host cycles.
- Sits between the host bus decode and the demod top; asserts holdDemod while a load is in progress.

Parameters:
- TBL_AW, 8, table address width; max entries = 2**TBL_AW.
- WR_GAP, 2, idle cycles after each sequencer write (register settle), range 0..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a table load when idle.
- hostRd  in  1  host read strobe.
- hostWr  in  4  host byte-lane write strobes; bit n = wrn.
- hostAddr  in  12  host address.
- hostDin  in  32  host write data.
- hostDout  out  32  host read data; combinational copy of demodDout.
- rd  out  1  demod read strobe.
- wr0, wr1, wr2, wr3  out  1 each  demod byte-lane write strobes.
- addr  out  12  demod address.
- din  out  32  demod write data.
- demodDout  in  32  demod read data.
- tblAddr  out  TBL_AW  table read address (registered).
- tblData  in  48  table entry: [47:44] lane mask, [43:32] addr, [31:0] data. Valid 1 cycle after tblAddr.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  sticky; set on completion, cleared on the next accepted start.
- holdDemod  out  1  equals busy.
- entryCount  out  TBL_AW+1  number of entries written in the last/current load.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; busy, done, holdDemod, tblAddr, entryCount, all internal sequencer strobe/addr/data registers = 0.
- Bus mux is combinational:
  - If hostRd or any hostWr bit is high, rd/wr*/addr/din = host values.
  - Otherwise the sequencer registers drive them.
  - Sequencer rd is always 0.
- States:
  - IDLE: start=1 -> FETCH; tblAddr=0, entryCount=0, done=0, busy=1.
  - FETCH: one wait cycle for the table -> LOAD.
  - LOAD: capture tblData.
    - Mask==0 -> DONE (end marker).
    - Otherwise latch mask/addr/data -> WRITE.
  - WRITE:
    - Host active this cycle: sequencer strobes stay 0 and state remains WRITE (retry).
    - Else: drive wr[n]=mask[n], addr, din for exactly one cycle; entryCount++; -> GAP, or FETCH if WR_GAP=0.
  - GAP: count WR_GAP cycles, then:
    - If tblAddr == 2**TBL_AW-1 -> DONE.
    - Else tblAddr++ -> FETCH.
  - DONE: busy=0, done=1 -> IDLE in the same cycle. busy is low in the DONE cycle.
- Timing: start sampled at cycle 0 gives the first write strobe at cycle 3. Each entry costs 3+WR_GAP cycles without host collisions.
- start while busy is ignored, with no restart.
- Host writes during a load are passed through unaltered; host data may be overwritten by later table entries (software contract).
- Reset mid-load aborts immediately: no partial strobe, done=0.

Decomposition:
- Shared package:
  - Entry field positions (MASK_HI=47, MASK_LO=44, ADDR_HI=43, ADDR_LO=32).
  - State encoding: IDLE, FETCH, LOAD, WRITE, GAP, DONE.
  - END_MASK=4'b0000.
- One sub-module: cfg_bus_mux (combinational host/sequencer mux plus hostActive detect). The FSM stays in the top.

Test Plan:
- Table {F,0x010,0x12345678}, {F,0x014,0xA5A5A5A5}, {F,0x018,0x00000001}, end; WR_GAP=2; start@0 -> wr0..3 high at cycles 3, 8, 13 with matching addr/din; busy low and done high at cycle 18; entryCount=3.
- Same table; host hostWr=4'b0001, hostAddr=0x100 at cycle 8 -> cycle 8 bus shows the host write only; sequencer write to 0x014 at cycle 9; all later writes shift +1; done at 19.
- Entry mask 4'b0101, addr 0x020 -> only wr0 and wr2 pulse, one cycle; wr1/wr3 stay 0.
- TBL_AW=2, four non-terminator entries -> 4 writes, no wrap to tblAddr 0, done=1, entryCount=4.
- Start pulse at cycles 0 and 5 -> a single load; entryCount reflects one pass only.
- Assert reset at cycle 9 -> busy=done=0 and strobes 0 immediately. Release, then start -> load restarts from tblAddr=0.

Source files
------------

// File: rtl/demod_cfg_sequencer_pkg.sv
// demod_cfg_sequencer_pkg: table entry layout, end marker and FSM state encoding for the config sequencer
package demod_cfg_sequencer_pkg;
  localparam int MASK_HI = 47;
  localparam int MASK_LO = 44;
  localparam int ADDR_HI = 43;
  localparam int ADDR_LO = 32;
  localparam logic [3:0] END_MASK = 4'b0000;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, GAP, DONE} state_e;
endpackage

// File: rtl/demod_cfg_sequencer_bus_mux.sv
// cfg_bus_mux: host/sequencer demod bus mux; host wins whenever it strobes.
//   host_*_i : host read/write request    seq_*_i : sequencer write request
//   rd_o/wr_o/addr_o/din_o : demod bus    host_active_o : host owns the bus this cycle
module cfg_bus_mux
  import demod_cfg_sequencer_pkg::*;
(
  input  logic        host_rd_i,
  input  logic [3:0]  host_wr_i,
  input  logic [11:0] host_addr_i,
  input  logic [31:0] host_din_i,
  input  logic [3:0]  seq_wr_i,
  input  logic [11:0] seq_addr_i,
  input  logic [31:0] seq_din_i,
  output logic        rd_o,
  output logic [3:0]  wr_o,
  output logic [11:0] addr_o,
  output logic [31:0] din_o,
  output logic        host_active_o
);
  assign host_active_o = host_rd_i | (|host_wr_i);
  // the sequencer never reads, so rd is the host strobe in both mux positions
  assign rd_o   = host_rd_i;
  assign wr_o   = host_active_o ? host_wr_i : seq_wr_i;
  assign addr_o = host_active_o ? host_addr_i : seq_addr_i;
  assign din_o  = host_active_o ? host_din_i : seq_din_i;
endmodule

// File: rtl/demod_cfg_sequencer.sv
// demod_cfg_sequencer: walks a {mask,addr,data} table and issues byte-lane writes to the demod bus, yielding to the host.
//   clk, reset (async active-low), start : control
//   hostRd/hostWr/hostAddr/hostDin/hostDout : host side of the register bus
//   rd/wr0..wr3/addr/din/demodDout : demod side of the register bus
//   tblAddr/tblData : synchronous table port (data valid one cycle after address)
//   busy/done/holdDemod/entryCount : load status
module demod_cfg_sequencer
  import demod_cfg_sequencer_pkg::*;
#(
  parameter int TBL_AW = 8,
  parameter int WR_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hostRd,
  input  logic [3:0]        hostWr,
  input  logic [11:0]       hostAddr,
  input  logic [31:0]       hostDin,
  output logic [31:0]       hostDout,
  output logic              rd,
  output logic              wr0,
  output logic              wr1,
  output logic              wr2,
  output logic              wr3,
  output logic [11:0]       addr,
  output logic [31:0]       din,
  input  logic [31:0]       demodDout,
  output logic [TBL_AW-1:0] tblAddr,
  input  logic [47:0]       tblData,
  output logic              busy,
  output logic              done,
  output logic              holdDemod,
  output logic [TBL_AW:0]   entryCount
);
  localparam logic [3:0] GAP_LAST = (WR_GAP == 0) ? 4'd0 : 4'(WR_GAP - 1);

  state_e            state_q;
  logic [3:0]        seq_wr_q;
  logic [11:0]       seq_addr_q;
  logic [31:0]       seq_din_q;
  logic [3:0]        gap_cnt_q;
  logic [TBL_AW-1:0] tbl_addr_q;
  logic [TBL_AW:0]   entry_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              host_active;
  logic [3:0]        wr;
  logic              wrote;
  logic              adv;

  cfg_bus_mux u_mux (
    .host_rd_i    (hostRd),
    .host_wr_i    (hostWr),
    .host_addr_i  (hostAddr),
    .host_din_i   (hostDin),
    .seq_wr_i     (seq_wr_q),
    .seq_addr_i   (seq_addr_q),
    .seq_din_i    (seq_din_q),
    .rd_o         (rd),
    .wr_o         (wr),
    .addr_o       (addr),
    .din_o        (din),
    .host_active_o(host_active)
  );

  // strobes are loaded on entry to WRITE so they reach the bus in the WRITE cycle;
  // they are held through host collisions and dropped once the bus was actually ours
  assign wrote = (state_q == WRITE) && !host_active;
  // end of an entry: right after the write when there is no gap, else at the last gap cycle
  assign adv = (wrote && WR_GAP == 0) || (state_q == GAP && gap_cnt_q == GAP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      seq_wr_q    <= '0;
      seq_addr_q  <= '0;
      seq_din_q   <= '0;
      gap_cnt_q   <= '0;
      tbl_addr_q  <= '0;
      entry_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q     <= FETCH;
          tbl_addr_q  <= '0;
          entry_cnt_q <= '0;
          done_q      <= 1'b0;
          busy_q      <= 1'b1;
        end
        FETCH: state_q <= LOAD;
        LOAD: if (tblData[MASK_HI:MASK_LO] == END_MASK) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          seq_wr_q   <= tblData[MASK_HI:MASK_LO];
          seq_addr_q <= tblData[ADDR_HI:ADDR_LO];
          seq_din_q  <= tblData[31:0];
          state_q    <= WRITE;
        end
        WRITE: if (wrote) begin
          seq_wr_q    <= '0;
          entry_cnt_q <= entry_cnt_q + 1'b1;
          gap_cnt_q   <= '0;
          state_q     <= GAP;
        end
        GAP: gap_cnt_q <= gap_cnt_q + 1'b1;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (adv) begin
        if (tbl_addr_q == '1) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          tbl_addr_q <= tbl_addr_q + 1'b1;
          state_q    <= FETCH;
        end
      end
    end
  end

  assign {wr3, wr2, wr1, wr0} = wr;
  assign hostDout   = demodDout;
  assign tblAddr    = tbl_addr_q;
  assign entryCount = entry_cnt_q;
  assign busy       = busy_q;
  assign holdDemod  = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_demod_cfg_sequencer.sv
// tb_demod_cfg_sequencer: directed checks of table loads, host collisions, end-of-table and reset abort
module tb_demod_cfg_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic        host_rd;
  logic [3:0]  host_wr;
  logic [11:0] host_addr;
  logic [31:0] host_din;
  logic [31:0] demod_dout;

  logic        rd_a, wr0_a, wr1_a, wr2_a, wr3_a, busy_a, done_a, hold_a;
  logic [11:0] addr_a;
  logic [31:0] din_a, hdout_a;
  logic [7:0]  ta_a;
  logic [8:0]  ec_a;
  logic [47:0] td_a;
  logic [47:0] tbl_a [256];

  logic        rd_b, wr0_b, wr1_b, wr2_b, wr3_b, busy_b, done_b, hold_b;
  logic [11:0] addr_b;
  logic [31:0] din_b, hdout_b;
  logic [1:0]  ta_b;
  logic [2:0]  ec_b;
  logic [47:0] td_b;
  logic [47:0] tbl_b [4];

  always_ff @(posedge clk) td_a <= tbl_a[ta_a];
  always_ff @(posedge clk) td_b <= tbl_b[ta_b];

  demod_cfg_sequencer #(.TBL_AW(8), .WR_GAP(2)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a),
    .hostRd(host_rd), .hostWr(host_wr), .hostAddr(host_addr), .hostDin(host_din), .hostDout(hdout_a),
    .rd(rd_a), .wr0(wr0_a), .wr1(wr1_a), .wr2(wr2_a), .wr3(wr3_a), .addr(addr_a), .din(din_a),
    .demodDout(demod_dout), .tblAddr(ta_a), .tblData(td_a),
    .busy(busy_a), .done(done_a), .holdDemod(hold_a), .entryCount(ec_a)
  );

  demod_cfg_sequencer #(.TBL_AW(2), .WR_GAP(0)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b),
    .hostRd(host_rd), .hostWr(host_wr), .hostAddr(host_addr), .hostDin(host_din), .hostDout(hdout_b),
    .rd(rd_b), .wr0(wr0_b), .wr1(wr1_b), .wr2(wr2_b), .wr3(wr3_b), .addr(addr_b), .din(din_b),
    .demodDout(demod_dout), .tblAddr(ta_b), .tblData(td_b),
    .busy(busy_b), .done(done_b), .holdDemod(hold_b), .entryCount(ec_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int nwr;
  logic        sel;
  logic [3:0]  lw [64];
  logic [11:0] la [64];
  logic [31:0] ld [64];
  logic        lb [64];
  logic        ldn [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic [3:0] hw, input logic [11:0] ha, input logic [31:0] hd);
    start_a   = st && !sel;
    start_b   = st && sel;
    host_wr   = hw;
    host_addr = ha;
    host_din  = hd;
    #2;
    lw[cyc]  = sel ? {wr3_b, wr2_b, wr1_b, wr0_b} : {wr3_a, wr2_a, wr1_a, wr0_a};
    la[cyc]  = sel ? addr_b : addr_a;
    ld[cyc]  = sel ? din_b : din_a;
    lb[cyc]  = sel ? busy_b : busy_a;
    ldn[cyc] = sel ? done_b : done_a;
    if (lw[cyc] != 4'b0000) nwr++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_run(input logic b);
    sel = b;
    cyc = 0;
    nwr = 0;
    for (int i = 0; i < 64; i++) begin
      lw[i] = 'x; la[i] = 'x; ld[i] = 'x; lb[i] = 'x; ldn[i] = 'x;
    end
  endtask

  // n cycles, start at cycle 0 (and again at s2), one host byte-0 write at cycle hc
  task automatic run(input int n, input logic b, input int s2, input int hc);
    begin_run(b);
    for (int k = 0; k < n; k++)
      step(k == 0 || k == s2, k == hc ? 4'b0001 : 4'b0000,
           k == hc ? 12'h100 : 12'h000, k == hc ? 32'hDEADBEEF : 32'h0);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 256; i++) tbl_a[i] = '0;
    tbl_a[0] = {4'hF, 12'h010, 32'h12345678};
    tbl_a[1] = {4'hF, 12'h014, 32'hA5A5A5A5};
    tbl_a[2] = {4'hF, 12'h018, 32'h00000001};
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    host_rd = 1'b0; host_wr = '0; host_addr = '0; host_din = '0;
    demod_dout = 32'h0BADCAFE;
    sel = 1'b0;
    load_t1();
    tbl_b[0] = {4'hF, 12'h030, 32'h00000011};
    tbl_b[1] = {4'h3, 12'h031, 32'h00000022};
    tbl_b[2] = {4'hC, 12'h032, 32'h00000033};
    tbl_b[3] = {4'h1, 12'h033, 32'h00000044};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {busy_a, hold_a}, 2'b00);
    chk("rst_done", done_a, 1'b0);
    chk("rst_tbladdr", ta_a, 8'h00);
    chk("rst_count", ec_a, 9'd0);
    chk("rst_wr", {wr3_a, wr2_a, wr1_a, wr0_a}, 4'b0000);
    host_rd = 1'b1; host_addr = 12'h055;
    #1;
    chk("host_rd_pass", {rd_a, addr_a}, {1'b1, 12'h055});
    chk("host_dout", hdout_a, 32'h0BADCAFE);
    host_rd = 1'b0; host_addr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic three-entry load, WR_GAP=2
    run(22, 1'b0, -1, -1);
    chk("t1_w0", {lw[3], la[3], ld[3]}, {4'hF, 12'h010, 32'h12345678});
    chk("t1_w1", {lw[8], la[8], ld[8]}, {4'hF, 12'h014, 32'hA5A5A5A5});
    chk("t1_w2", {lw[13], la[13], ld[13]}, {4'hF, 12'h018, 32'h00000001});
    chk("t1_nwr", nwr, 3);
    chk("t1_busy1", lb[1], 1'b1);
    chk("t1_c17", {lb[17], ldn[17]}, 2'b10);
    chk("t1_c18", {lb[18], ldn[18]}, 2'b01);
    chk("t1_count", ec_a, 9'd3);

    // host write collides with the second sequencer write
    run(24, 1'b0, -1, 8);
    chk("t2_done_clr", ldn[1], 1'b0);
    chk("t2_w0", {lw[3], la[3], ld[3]}, {4'hF, 12'h010, 32'h12345678});
    chk("t2_host", {lw[8], la[8], ld[8]}, {4'h1, 12'h100, 32'hDEADBEEF});
    chk("t2_w1", {lw[9], la[9], ld[9]}, {4'hF, 12'h014, 32'hA5A5A5A5});
    chk("t2_w2", {lw[14], la[14], ld[14]}, {4'hF, 12'h018, 32'h00000001});
    chk("t2_nwr", nwr, 4);
    chk("t2_c18", {lb[18], ldn[18]}, 2'b10);
    chk("t2_c19", {lb[19], ldn[19]}, 2'b01);
    chk("t2_count", ec_a, 9'd3);

    // partial lane mask, second start while busy is ignored
    tbl_a[0] = {4'h5, 12'h020, 32'hCAFEF00D};
    tbl_a[1] = '0;
    run(16, 1'b0, 5, -1);
    chk("t3_w0", {lw[3], la[3], ld[3]}, {4'h5, 12'h020, 32'hCAFEF00D});
    chk("t3_nwr", nwr, 1);
    chk("t3_c8", {lb[8], ldn[8]}, 2'b01);
    chk("t3_count", ec_a, 9'd1);

    // full 4-entry table, no terminator, WR_GAP=0
    run(20, 1'b1, -1, -1);
    chk("t4_w0", {lw[3], la[3], ld[3]}, {4'hF, 12'h030, 32'h00000011});
    chk("t4_w1", {lw[6], la[6], ld[6]}, {4'h3, 12'h031, 32'h00000022});
    chk("t4_w2", {lw[9], la[9], ld[9]}, {4'hC, 12'h032, 32'h00000033});
    chk("t4_w3", {lw[12], la[12], ld[12]}, {4'h1, 12'h033, 32'h00000044});
    chk("t4_nwr", nwr, 4);
    chk("t4_c12", {lb[12], ldn[12]}, 2'b10);
    chk("t4_c13", {lb[13], ldn[13]}, 2'b01);
    chk("t4_count", ec_b, 3'd4);
    chk("t4_tbladdr", ta_b, 2'd3);

    // reset in the middle of a load, then reload from entry 0
    load_t1();
    begin_run(1'b0);
    for (int k = 0; k < 9; k++) step(k == 0, 4'b0000, 12'h000, 32'h0);
    chk("t5_pre_count", ec_a, 9'd2);
    rst_n = 1'b0;
    step(1'b0, 4'b0000, 12'h000, 32'h0);
    chk("t5_rst_c9", {lb[9], ldn[9], lw[9]}, 6'b000000);
    chk("t5_rst_count", ec_a, 9'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(22, 1'b0, -1, -1);
    chk("t5_w0", {lw[3], la[3], ld[3]}, {4'hF, 12'h010, 32'h12345678});
    chk("t5_c18", {lb[18], ldn[18]}, 2'b01);
    chk("t5_count", ec_a, 9'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
